bjack_ctrl: RTL and testbench

Game sequencer for the blackjack design. It turns the active-low START and NEW_CARD buttons into card requests to the card generator and accumulates the hand score, handling soft aces. It decides HOLD/BUST and presents the score as two BCD digits, D_H:D_L, to the display logic. It sits between the button inputs, the card generator and the seven-segment/LED drivers, all in the SYS_CLK domain.

---
 rtl/bjack_pkg.sv | 35 +++
 rtl/bjack_ctrl_if.sv | 25 ++
 rtl/bjack_btn_sync.sv | 36 +++
 rtl/bjack_ctrl.sv | 158 +++++++++++++++
 tb/tb_bjack_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bjack_pkg.sv
// Shared definitions for the blackjack design.
// Holds the card/score widths that the card generator and display driver also
// use, the scoring constants, the sequencer state enumeration and a card
// validity helper.
package bjack_pkg;

  localparam int unsigned CARD_W  = 4;
  localparam int unsigned SCORE_W = 5;
  localparam int unsigned CNT_W   = 3;

  typedef logic [CARD_W-1:0]  card_t;
  typedef logic [SCORE_W-1:0] score_t;
  typedef logic [CNT_W-1:0]   cnt_t;

  localparam card_t  ACE       = card_t'(1);
  localparam card_t  CARD_MAX  = card_t'(10);
  localparam score_t ACE_HIGH  = score_t'(11);
  localparam score_t BLACKJACK = score_t'(21);
  localparam score_t SOFT_ADJ  = score_t'(10);

  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StReq,
    StAdd,
    StFix,
    StDone
  } state_e;

  // Generator values outside 1..10 are not cards and must be skipped.
  function automatic logic card_valid(card_t c);
    return (c >= ACE) && (c <= CARD_MAX);
  endfunction

endpackage

// File: rtl/bjack_ctrl_if.sv
// Card request handshake between the game sequencer and the card generator.
//   CARD_REQ : sequencer asks for a card, held until a valid card is taken
//   CARD_VLD : generator strobe, CARD is valid while high
//   CARD     : card value, 1 = ace, 2..10 = face value
// master = sequencer side, slave = generator side.
interface bjack_ctrl_if;
  import bjack_pkg::*;

  logic  CARD_REQ;
  logic  CARD_VLD;
  card_t CARD;

  modport master (
    output CARD_REQ,
    input  CARD_VLD,
    input  CARD
  );

  modport slave (
    input  CARD_REQ,
    output CARD_VLD,
    output CARD
  );

endinterface

// File: rtl/bjack_btn_sync.sv
// Button synchronizer with registered falling-edge detector.
//   clk_i   : system clock
//   rst_i   : synchronous active-high reset; chain loads 1s (button released)
//   btn_i   : asynchronous active-low button
//   level_o : synchronized button level
//   fall_o  : one-cycle pulse, registered, on a synchronized 1->0 transition
module bjack_btn_sync #(
  parameter int unsigned Stages = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic level_o,
  output logic fall_o
);

  logic [Stages-1:0] sync_q;
  logic              last_q;
  logic              fall_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '1;
      last_q <= 1'b1;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[Stages-2:0], btn_i};
      last_q <= sync_q[Stages-1];
      fall_q <= last_q & ~sync_q[Stages-1];
    end
  end

  assign level_o = sync_q[Stages-1];
  assign fall_o  = fall_q;

endmodule

// File: rtl/bjack_ctrl.sv
// Blackjack game sequencer.
// Turns the START / NEW_CARD buttons into card requests, accumulates the hand
// score with soft-ace handling, decides HOLD/BUST and splits the score into
// BCD digits for the display.
//   SYS_CLK, RES : clock and synchronous active-high reset
//   START        : active-low new-game button (async)
//   NEW_CARD     : active-low draw button (async)
//   card_if      : request/strobe handshake to the card generator
//   SCORE        : binary hand score 0..26
//   D_H, D_L     : BCD tens/units of SCORE
//   CARD_CNT     : cards accepted, saturating at 7
//   HOLD, BUST   : hand finished at/above HOLD_AT, or over 21
module bjack_ctrl
  import bjack_pkg::*;
#(
  parameter int unsigned HOLD_AT     = 17,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                SYS_CLK,
  input  logic                RES,
  input  logic                START,
  input  logic                NEW_CARD,
  bjack_ctrl_if.master        card_if,
  output logic [SCORE_W-1:0]  SCORE,
  output logic [3:0]          D_L,
  output logic [1:0]          D_H,
  output logic [CNT_W-1:0]    CARD_CNT,
  output logic                HOLD,
  output logic                BUST
);

  localparam score_t HoldAt = score_t'(HOLD_AT);

  logic start_level;
  logic start_fall_unused;
  logic new_level_unused;
  logic draw;

  bjack_btn_sync #(
    .Stages (SYNC_STAGES)
  ) u_start_sync (
    .clk_i   (SYS_CLK),
    .rst_i   (RES),
    .btn_i   (START),
    .level_o (start_level),
    .fall_o  (start_fall_unused)
  );

  bjack_btn_sync #(
    .Stages (SYNC_STAGES)
  ) u_new_sync (
    .clk_i   (SYS_CLK),
    .rst_i   (RES),
    .btn_i   (NEW_CARD),
    .level_o (new_level_unused),
    .fall_o  (draw)
  );

  state_e state_q;
  score_t score_q;
  card_t  card_q;
  cnt_t   cnt_q;
  logic   soft_q;
  logic   hold_q;
  logic   bust_q;
  logic   req_q;

  always_ff @(posedge SYS_CLK) begin
    if (RES) begin
      state_q <= StIdle;
      score_q <= '0;
      card_q  <= '0;
      cnt_q   <= '0;
      soft_q  <= 1'b0;
      hold_q  <= 1'b0;
      bust_q  <= 1'b0;
      req_q   <= 1'b0;
    end else if (!start_level) begin
      // START low clears the hand from any state and parks in WAIT; it also
      // wins over a card strobe in the same cycle, so that card is lost.
      state_q <= StWait;
      score_q <= '0;
      cnt_q   <= '0;
      soft_q  <= 1'b0;
      hold_q  <= 1'b0;
      bust_q  <= 1'b0;
      req_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: ;
        StWait: begin
          if (draw) begin
            req_q   <= 1'b1;
            state_q <= StReq;
          end
        end
        StReq: begin
          if (card_if.CARD_VLD && card_valid(card_if.CARD)) begin
            card_q  <= card_if.CARD;
            req_q   <= 1'b0;
            state_q <= StAdd;
          end
        end
        StAdd: begin
          // Score is at most 20 here, so score+11 cannot wrap 5 bits.
          if (card_q == ACE && (score_q + ACE_HIGH) <= BLACKJACK) begin
            score_q <= score_q + ACE_HIGH;
            soft_q  <= 1'b1;
          end else begin
            score_q <= score_q + score_t'(card_q);
          end
          if (cnt_q != '1) begin
            cnt_q <= cnt_q + 1'b1;
          end
          state_q <= StFix;
        end
        StFix: begin
          if (score_q > BLACKJACK) begin
            if (soft_q) begin
              // Demote the soft ace and look at the hand again next cycle.
              score_q <= score_q - SOFT_ADJ;
              soft_q  <= 1'b0;
            end else begin
              bust_q  <= 1'b1;
              state_q <= StDone;
            end
          end else if (score_q >= HoldAt) begin
            hold_q  <= 1'b1;
            state_q <= StDone;
          end else begin
            state_q <= StWait;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign card_if.CARD_REQ = req_q;
  assign SCORE            = score_q;
  assign CARD_CNT         = cnt_q;
  assign HOLD             = hold_q;
  assign BUST             = bust_q;

  always_comb begin
    if (score_q >= score_t'(20)) begin
      D_H = 2'd2;
      D_L = 4'(score_q - score_t'(20));
    end else if (score_q >= score_t'(10)) begin
      D_H = 2'd1;
      D_L = 4'(score_q - score_t'(10));
    end else begin
      D_H = 2'd0;
      D_L = 4'(score_q);
    end
  end

endmodule

// File: tb/tb_bjack_ctrl.sv
module tb_bjack_ctrl;
  import bjack_pkg::*;

  localparam int unsigned HoldAt = 17;
  localparam int unsigned Sync   = 2;

  logic       SYS_CLK = 1'b0;
  logic       RES;
  logic       START;
  logic       NEW_CARD;
  logic [4:0] SCORE;
  logic [3:0] D_L;
  logic [1:0] D_H;
  logic [2:0] CARD_CNT;
  logic       HOLD;
  logic       BUST;

  bjack_ctrl_if card_if();

  bjack_ctrl #(
    .HOLD_AT     (HoldAt),
    .SYNC_STAGES (Sync)
  ) dut (
    .SYS_CLK  (SYS_CLK),
    .RES      (RES),
    .START    (START),
    .NEW_CARD (NEW_CARD),
    .card_if  (card_if),
    .SCORE    (SCORE),
    .D_L      (D_L),
    .D_H      (D_H),
    .CARD_CNT (CARD_CNT),
    .HOLD     (HOLD),
    .BUST     (BUST)
  );

  always #5 SYS_CLK = ~SYS_CLK;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Hand model: standard blackjack valuation of the list of cards drawn.
  int hand[$];
  int exp_score = 0;
  int exp_cnt   = 0;
  int exp_hold  = 0;
  int exp_bust  = 0;
  bit chk_en    = 1'b0;
  int junk_cards[2] = '{0, 15};

  task automatic model_eval();
    int hard;
    bit has_ace;
    hard    = 0;
    has_ace = 1'b0;
    foreach (hand[i]) begin
      hard += hand[i];
      if (hand[i] == 1) has_ace = 1'b1;
    end
    exp_score = (has_ace && hard + 10 <= 21) ? hard + 10 : hard;
    exp_bust  = (exp_score > 21) ? 1 : 0;
    exp_hold  = (!exp_bust && exp_score >= HoldAt) ? 1 : 0;
    exp_cnt   = (hand.size() > 7) ? 7 : hand.size();
  endtask

  task automatic model_clear();
    hand.delete();
    model_eval();
  endtask

  // Whenever the hand is settled, every output must match the model.
  always @(negedge SYS_CLK) begin
    if (chk_en) begin
      check("score", SCORE, exp_score);
      check("d_h", D_H, exp_score / 10);
      check("d_l", D_L, exp_score % 10);
      check("card_cnt", CARD_CNT, exp_cnt);
      check("hold", HOLD, exp_hold);
      check("bust", BUST, exp_bust);
      check("card_req_idle", card_if.CARD_REQ, 0);
    end
  end

  task automatic tick();
    @(posedge SYS_CLK);
    #1;
  endtask

  task automatic start_game();
    chk_en = 1'b0;
    START  = 1'b0;
    repeat (Sync + 2) tick();
    START = 1'b1;
    repeat (Sync + 2) tick();
    model_clear();
    chk_en = 1'b1;
    tick();
  endtask

  task automatic draw(input int c, input bit junk);
    int waited;
    int prev;
    int mid;
    int lat;
    chk_en   = 1'b0;
    prev     = exp_score;
    waited   = 0;
    NEW_CARD = 1'b0;
    while (card_if.CARD_REQ !== 1'b1 && waited < 20) begin
      tick();
      waited++;
    end
    check("req_latency", waited, Sync + 2);
    NEW_CARD = 1'b1;
    if (junk) begin
      foreach (junk_cards[i]) begin
        card_if.CARD_VLD = 1'b1;
        card_if.CARD     = card_t'(junk_cards[i]);
        tick();
        card_if.CARD_VLD = 1'b0;
        card_if.CARD     = '0;
        check("junk_req_held", card_if.CARD_REQ, 1);
        check("junk_score", SCORE, prev);
        tick();
      end
    end
    card_if.CARD_VLD = 1'b1;
    card_if.CARD     = card_t'(c);
    tick();
    card_if.CARD_VLD = 1'b0;
    card_if.CARD     = '0;
    check("req_drop", card_if.CARD_REQ, 0);
    mid = prev + ((c == 1 && prev + 11 <= 21) ? 11 : c);
    hand.push_back(c);
    model_eval();
    lat = (mid != exp_score) ? 3 : 2;
    tick();
    check("score_add", SCORE, mid);
    check("flags_early", {HOLD, BUST}, 0);
    if (lat == 3) begin
      tick();
      check("score_demote", SCORE, mid - 10);
      check("flags_demote", {HOLD, BUST}, 0);
    end
    tick();
    check("hold_final", HOLD, exp_hold);
    check("bust_final", BUST, exp_bust);
    check("score_final", SCORE, exp_score);
    chk_en = 1'b1;
    repeat (2) tick();
  endtask

  task automatic ignored_draw(input string name);
    bit seen;
    seen     = 1'b0;
    NEW_CARD = 1'b0;
    repeat (4) begin
      tick();
      if (card_if.CARD_REQ) seen = 1'b1;
    end
    NEW_CARD = 1'b1;
    repeat (6) begin
      tick();
      if (card_if.CARD_REQ) seen = 1'b1;
    end
    check(name, seen, 0);
  endtask

  initial begin
    int waited;
    bit seen;
    RES              = 1'b1;
    START            = 1'b1;
    NEW_CARD         = 1'b1;
    card_if.CARD_VLD = 1'b0;
    card_if.CARD     = '0;
    repeat (3) tick();
    RES = 1'b0;
    model_clear();
    check("rst_score", SCORE, 0);
    check("rst_req", card_if.CARD_REQ, 0);
    check("rst_hold_bust", {HOLD, BUST}, 0);
    check("rst_cnt", CARD_CNT, 0);
    chk_en = 1'b1;
    repeat (3) tick();
    ignored_draw("idle_no_req");

    // 10, 7 -> hold at 17; further draws ignored
    start_game();
    draw(10, 0);
    draw(7, 0);
    check("lit_h1_score", SCORE, 17);
    check("lit_h1_dh", D_H, 1);
    check("lit_h1_dl", D_L, 7);
    check("lit_h1_hold", HOLD, 1);
    check("lit_h1_bust", BUST, 0);
    check("lit_h1_cnt", CARD_CNT, 2);
    ignored_draw("done_no_req");

    // 10, 5, 9 -> bust at 24
    start_game();
    draw(10, 0);
    draw(5, 0);
    draw(9, 0);
    check("lit_h2_score", SCORE, 24);
    check("lit_h2_dh", D_H, 2);
    check("lit_h2_dl", D_L, 4);
    check("lit_h2_bust", BUST, 1);
    check("lit_h2_hold", HOLD, 0);

    // soft 17 holds
    start_game();
    draw(1, 0);
    draw(6, 0);
    check("lit_h3_score", SCORE, 17);
    check("lit_h3_hold", HOLD, 1);

    // ace, 5, 9 -> 15 after demotion, then 4 -> 19
    start_game();
    draw(1, 0);
    check("lit_h4_ace", SCORE, 11);
    draw(5, 0);
    draw(9, 0);
    check("lit_h4_15", SCORE, 15);
    check("lit_h4_nohold", HOLD, 0);
    draw(4, 0);
    check("lit_h4_19", SCORE, 19);
    check("lit_h4_hold", HOLD, 1);

    // ace, ace -> 12 soft; 10 -> 12 hard; 5 -> 17
    start_game();
    draw(1, 0);
    draw(1, 0);
    check("lit_h5_12", SCORE, 12);
    draw(10, 0);
    check("lit_h5_demote", SCORE, 12);
    check("lit_h5_open", {HOLD, BUST}, 0);
    draw(5, 0);
    check("lit_h5_hold", HOLD, 1);
    check("lit_h5_cnt", CARD_CNT, 4);

    // card count saturates at 7
    start_game();
    for (int i = 0; i < 6; i++) draw(1, 0);
    draw(10, 0);
    check("lit_h6_16", SCORE, 16);
    check("lit_h6_cnt7", CARD_CNT, 7);
    draw(1, 0);
    check("lit_h6_17", SCORE, 17);
    check("lit_h6_sat", CARD_CNT, 7);

    // junk cards 0 and 15 ignored, then 3 accepted
    start_game();
    draw(3, 1);
    check("lit_h7_score", SCORE, 3);
    draw(5, 0);

    // START low coinciding with CARD_VLD: card discarded, hand cleared
    chk_en   = 1'b0;
    NEW_CARD = 1'b0;
    waited   = 0;
    while (card_if.CARD_REQ !== 1'b1 && waited < 20) begin
      tick();
      waited++;
    end
    check("abort_req_up", card_if.CARD_REQ, 1);
    NEW_CARD = 1'b1;
    START    = 1'b0;
    repeat (Sync) tick();
    card_if.CARD_VLD = 1'b1;
    card_if.CARD     = card_t'(9);
    tick();
    card_if.CARD_VLD = 1'b0;
    card_if.CARD     = '0;
    check("abort_req", card_if.CARD_REQ, 0);
    check("abort_score", SCORE, 0);
    check("abort_cnt", CARD_CNT, 0);
    seen     = 1'b0;
    NEW_CARD = 1'b0;
    repeat (2) tick();
    NEW_CARD = 1'b1;
    repeat (6) begin
      tick();
      if (card_if.CARD_REQ) seen = 1'b1;
    end
    check("abort_draw_ignored", seen, 0);
    START = 1'b1;
    repeat (Sync + 2) tick();
    model_clear();
    chk_en = 1'b1;
    tick();
    draw(3, 0);
    check("lit_h8_score", SCORE, 3);

    // RES in the middle of a request
    chk_en   = 1'b0;
    NEW_CARD = 1'b0;
    waited   = 0;
    while (card_if.CARD_REQ !== 1'b1 && waited < 20) begin
      tick();
      waited++;
    end
    check("res_req_up", card_if.CARD_REQ, 1);
    NEW_CARD         = 1'b1;
    RES              = 1'b1;
    card_if.CARD_VLD = 1'b1;
    card_if.CARD     = card_t'(4);
    tick();
    RES              = 1'b0;
    card_if.CARD_VLD = 1'b0;
    card_if.CARD     = '0;
    check("res_req", card_if.CARD_REQ, 0);
    check("res_score", SCORE, 0);
    check("res_cnt", CARD_CNT, 0);
    check("res_flags", {HOLD, BUST}, 0);
    check("res_bcd", {D_H, D_L}, 0);
    model_clear();
    chk_en = 1'b1;
    repeat (3) tick();
    ignored_draw("res_idle_no_req");

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
